// File: rtl/alto_task_next_modifiers.sv
// rtl/alto_task_next_modifiers.sv - per-task registered NEXT-modifier decode with bypass and ALU carry latch
module alto_task_next_modifiers #(
    parameter int TASKS     = 16,
    parameter int MOD_WIDTH = 10,
    localparam int TASK_BITS = $clog2(TASKS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 advance_i,
    input  logic [TASK_BITS-1:0] cur_task_i,
    input  logic [TASK_BITS-1:0] fetch_task_i,
    input  logic [3:0]           f2_i,
    input  logic                 load_l_i,
    input  logic [15:0]          bus_i,
    input  logic [15:0]          shifter_i,
    input  logic                 alu_carry_i,
    input  logic                 ext_valid_i,
    input  logic [MOD_WIDTH-1:0] ext_mod_i,
    output logic [MOD_WIDTH-1:0] modifiers_o,
    output logic [TASKS-1:0]     pending_o,
    output logic                 carry_q_o
);

    localparam logic [3:0] ALTO_F2_BUS_ZERO = 4'd1;
    localparam logic [3:0] ALTO_F2_SH_NEG   = 4'd2;
    localparam logic [3:0] ALTO_F2_SH_ZERO  = 4'd3;
    localparam logic [3:0] ALTO_F2_BUS      = 4'd4;
    localparam logic [3:0] ALTO_F2_ALUCY    = 4'd5;

    logic [MOD_WIDTH-1:0] pend_q [TASKS];
    logic [MOD_WIDTH-1:0] pend_d [TASKS];
    logic [TASKS-1:0]     pending_q;
    logic [TASKS-1:0]     pending_d;
    logic                 carry_q;
    logic                 carry_d;
    logic [MOD_WIDTH-1:0] new_mod;
    logic                 bypass;

    always_comb begin
        new_mod = '0;
        case (f2_i)
            ALTO_F2_BUS_ZERO: new_mod[0] = (bus_i == 16'h0000);
            ALTO_F2_SH_NEG:   new_mod[0] = shifter_i[15];
            ALTO_F2_SH_ZERO:  new_mod[0] = (shifter_i == 16'h0000);
            ALTO_F2_BUS:      new_mod    = bus_i[MOD_WIDTH-1:0];
            // ALUCY tests the carry latched by an earlier instruction, never this one's
            ALTO_F2_ALUCY:    new_mod[0] = carry_q;
            default:          new_mod    = '0;
        endcase
        if (ext_valid_i) begin
            new_mod = new_mod | ext_mod_i;
        end
    end

    assign bypass = advance_i && (fetch_task_i == cur_task_i);

    always_comb begin
        pend_d = pend_q;
        if (advance_i) begin
            if (bypass) begin
                pend_d[cur_task_i] = '0;
            end else begin
                pend_d[fetch_task_i] = '0;
                pend_d[cur_task_i]   = new_mod;
            end
        end
        for (int t = 0; t < TASKS; t++) begin
            pending_d[t] = |pend_d[t];
        end
    end

    assign carry_d     = (advance_i && load_l_i) ? alu_carry_i : carry_q;
    assign modifiers_o = bypass ? new_mod : pend_q[fetch_task_i];
    assign pending_o   = pending_q;
    assign carry_q_o   = carry_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int t = 0; t < TASKS; t++) begin
                pend_q[t] <= '0;
            end
            pending_q <= '0;
            carry_q   <= 1'b0;
        end else begin
            for (int t = 0; t < TASKS; t++) begin
                pend_q[t] <= pend_d[t];
            end
            pending_q <= pending_d;
            carry_q   <= carry_d;
        end
    end

endmodule

// File: tb/tb_alto_task_next_modifiers.sv
// tb/tb_alto_task_next_modifiers.sv - self-checking bench for alto_task_next_modifiers
module tb_alto_task_next_modifiers;

    typedef struct packed {
        logic        adv;
        logic [3:0]  cur;
        logic [3:0]  fetch;
        logic [3:0]  f2;
        logic        ld;
        logic        cy;
        logic [15:0] bus;
        logic [15:0] sh;
        logic        ev;
        logic [9:0]  em;
        logic [9:0]  xm;
        logic [15:0] xp;
        logic        xc;
    } vec_t;

    typedef struct packed {
        logic [9:0]  m;
        logic [15:0] p;
        logic        c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        adv, ld, cy, ev;
    logic [3:0]  cur, fetch, f2;
    logic [15:0] bus, sh;
    logic [9:0]  em;
    logic [9:0]  mod;
    logic [15:0] pend;
    logic        carry;

    logic        p_adv;
    logic [1:0]  p_cur, p_fetch;
    logic [3:0]  p_f2;
    logic [15:0] p_bus;
    logic [0:0]  p_mod;
    logic [3:0]  p_pend;
    logic        p_carry;

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    alto_task_next_modifiers dut (
        .clk_i(clk), .rst_i(rst), .advance_i(adv), .cur_task_i(cur), .fetch_task_i(fetch),
        .f2_i(f2), .load_l_i(ld), .bus_i(bus), .shifter_i(sh), .alu_carry_i(cy),
        .ext_valid_i(ev), .ext_mod_i(em), .modifiers_o(mod), .pending_o(pend), .carry_q_o(carry)
    );

    alto_task_next_modifiers #(.TASKS(4), .MOD_WIDTH(1)) dut_p (
        .clk_i(clk), .rst_i(rst), .advance_i(p_adv), .cur_task_i(p_cur), .fetch_task_i(p_fetch),
        .f2_i(p_f2), .load_l_i(1'b0), .bus_i(p_bus), .shifter_i(16'h0000), .alu_carry_i(1'b0),
        .ext_valid_i(1'b0), .ext_mod_i(1'b0), .modifiers_o(p_mod), .pending_o(p_pend), .carry_q_o(p_carry)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // entered one time unit after a rising edge; leaves one unit after the next
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        adv = v.adv; cur = v.cur; fetch = v.fetch; f2 = v.f2; ld = v.ld; cy = v.cy;
        bus = v.bus; sh = v.sh; ev = v.ev; em = v.em;
        sb.push_back('{m: v.xm, p: v.xp, c: v.xc});
        #3;
        e = sb.pop_front();
        chk($sformatf("v%0d modifiers", idx), {22'd0, mod}, {22'd0, e.m});
        @(posedge clk);
        #1;
        chk($sformatf("v%0d pending", idx), {16'd0, pend}, {16'd0, e.p});
        chk($sformatf("v%0d carry", idx), {31'd0, carry}, {31'd0, e.c});
    endtask

    task automatic p_apply(input logic a, input logic [1:0] c, input logic [1:0] f,
                           input logic [3:0] code, input logic [15:0] b,
                           input logic xm, input logic [3:0] xp, input string nm);
        exp_t e;
        p_adv = a; p_cur = c; p_fetch = f; p_f2 = code; p_bus = b;
        sb.push_back('{m: {9'd0, xm}, p: {12'd0, xp}, c: 1'b0});
        #3;
        e = sb.pop_front();
        chk({nm, " modifiers"}, {31'd0, p_mod}, {22'd0, e.m});
        @(posedge clk);
        #1;
        chk({nm, " pending"}, {28'd0, p_pend}, {16'd0, e.p});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        adv = 0; cur = 0; fetch = 0; f2 = 0; ld = 0; cy = 0; bus = 0; sh = 0; ev = 0; em = 0;
        p_adv = 0; p_cur = 0; p_fetch = 0; p_f2 = 0; p_bus = 0;

        //          adv cur fetch f2 ld cy bus       sh        ev em       xm       xp        xc
        tbl.push_back('{1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 10'h000, 10'h000, 16'h0000, 1'b0});
        tbl.push_back('{1'b1, 4'd0, 4'd0, 4'd4, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 10'h000, 10'h3FF, 16'h0000, 1'b0});
        tbl.push_back('{1'b1, 4'd0, 4'd5, 4'd2, 1'b0, 1'b0, 16'h0000, 16'h8000, 1'b0, 10'h000, 10'h000, 16'h0001, 1'b0});
        for (int i = 0; i < 3; i++)
            tbl.push_back('{1'b0, 4'd0, 4'd5, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 10'h000, 10'h000, 16'h0001, 1'b0});
        tbl.push_back('{1'b1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 10'h000, 10'h001, 16'h0000, 1'b0});
        tbl.push_back('{1'b1, 4'd3, 4'd1, 4'd4, 1'b1, 1'b1, 16'h02A5, 16'h0000, 1'b0, 10'h000, 10'h000, 16'h0008, 1'b1});
        tbl.push_back('{1'b0, 4'd0, 4'd3, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 10'h000, 10'h2A5, 16'h0008, 1'b1});
        tbl.push_back('{1'b1, 4'd1, 4'd1, 4'd5, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 10'h000, 10'h001, 16'h0008, 1'b0});
        tbl.push_back('{1'b1, 4'd1, 4'd1, 4'd5, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 10'h000, 10'h000, 16'h0008, 1'b0});
        tbl.push_back('{1'b1, 4'd4, 4'd4, 4'd1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 10'h0F0, 10'h0F1, 16'h0008, 1'b0});
        tbl.push_back('{1'b1, 4'd7, 4'd3, 4'd3, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 10'h000, 10'h2A5, 16'h0080, 1'b0});
        tbl.push_back('{1'b1, 4'd7, 4'd2, 4'd4, 1'b0, 1'b0, 16'h0002, 16'h0000, 1'b0, 10'h000, 10'h000, 16'h0080, 1'b0});
        tbl.push_back('{1'b0, 4'd0, 4'd7, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 10'h000, 10'h002, 16'h0080, 1'b0});
        tbl.push_back('{1'b1, 4'd9, 4'd7, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 10'h3C0, 10'h002, 16'h0200, 1'b0});
        tbl.push_back('{1'b0, 4'd0, 4'd9, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 10'h000, 10'h3C0, 16'h0200, 1'b0});
        tbl.push_back('{1'b1, 4'd9, 4'd9, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 10'h000, 10'h000, 16'h0000, 1'b0});
        tbl.push_back('{1'b1, 4'd1, 4'd1, 4'd1, 1'b0, 1'b0, 16'h0001, 16'h0000, 1'b0, 10'h000, 10'h000, 16'h0000, 1'b0});
        tbl.push_back('{1'b1, 4'd1, 4'd1, 4'd2, 1'b0, 1'b0, 16'h0000, 16'h7FFF, 1'b0, 10'h000, 10'h000, 16'h0000, 1'b0});
        tbl.push_back('{1'b0, 4'd1, 4'd1, 4'd0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 10'h000, 10'h000, 16'h0000, 1'b0});
        tbl.push_back('{1'b1, 4'd1, 4'd1, 4'd5, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 10'h000, 10'h000, 16'h0000, 1'b0});

        @(posedge clk);
        #1;
        chk("reset pending", {16'd0, pend}, 32'd0);
        chk("reset carry", {31'd0, carry}, 32'd0);
        chk("reset modifiers", {22'd0, mod}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // narrow instance: 1-bit BUS, then overwrite of task 1 without a fetch
        p_apply(1'b1, 2'd2, 2'd2, 4'd4, 16'h0003, 1'b1, 4'b0000, "p bypass bus");
        p_apply(1'b1, 2'd1, 2'd0, 4'd4, 16'h0000, 1'b0, 4'b0000, "p capture 0");
        p_apply(1'b1, 2'd1, 2'd0, 4'd4, 16'h0001, 1'b0, 4'b0010, "p capture 1");
        p_apply(1'b0, 2'd0, 2'd1, 4'd0, 16'h0000, 1'b1, 4'b0010, "p fetch 1");
        p_apply(1'b1, 2'd3, 2'd1, 4'd0, 16'h0000, 1'b1, 4'b0000, "p fetch clears");

        // mid-cycle asynchronous reset with pend[3] = 2A5 and carry set
        apply('{1'b1, 4'd3, 4'd1, 4'd4, 1'b1, 1'b1, 16'h02A5, 16'h0000, 1'b0, 10'h000, 10'h000, 16'h0008, 1'b1}, 100);
        adv = 0; cur = 0; fetch = 3; f2 = 0; ld = 0; cy = 0; bus = 0; sh = 0; ev = 0; em = 0;
        #2;
        rst = 1'b1;
        #1;
        chk("async reset pending", {16'd0, pend}, 32'd0);
        chk("async reset carry", {31'd0, carry}, 32'd0);
        chk("async reset fetch 3", {22'd0, mod}, 32'd0);
        adv = 1; cur = 2; fetch = 2; f2 = 4; bus = 16'h0011;
        #1;
        chk("reset bypass", {22'd0, mod}, 32'h011);
        @(posedge clk);
        #1;
        chk("reset held pending", {16'd0, pend}, 32'd0);
        rst = 1'b0;
        apply('{1'b0, 4'd0, 4'd3, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 10'h000, 10'h000, 16'h0000, 1'b0}, 101);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/alto_task_next_modifiers.md
# alto_task_next_modifiers

Parametrised, registered successor to the Alto combinational NEXT-modifier decode. It evaluates the F2 branch condition of the microinstruction completing this cycle and stores the result per task, because the owning task's next fetch may occur cycles later after a task switch. It presents the stored, or bypassed, modifier bits for the task being fetched, so that they can be ORed into NEXT. It also owns the latched ALU carry used by ALUCY. It sits between the datapath (bus, shifter, ALU) and the microaddress mux in the control section.

## Interface
- TASKS, 16: number of microcode tasks; power of two, 2..16.
- MOD_WIDTH, 10: width of the modifier field; 1..16.
- TASK_BITS, $clog2(TASKS): task-number width; derived, never overridden.
- clk_i  input  1  system clock; all state changes on its rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- advance_i  input  1  current microinstruction completes this cycle; not asserted while stalled.
- cur_task_i  input  TASK_BITS  task owning the completing instruction.
- fetch_task_i  input  TASK_BITS  task whose next microinstruction is addressed this cycle.
- f2_i  input  4  F2 field of the completing instruction.
- load_l_i  input  1  completing instruction loads L; enables the carry latch.
- bus_i  input  16  current bus value.
- shifter_i  input  16  current shifter output.
- alu_carry_i  input  1  ALU carry-out of the completing instruction.
- ext_valid_i  input  1  task-specific modifier contribution is valid, e.g. emulator IR dispatch.
- ext_mod_i  input  MOD_WIDTH  task-specific modifier bits; ORed in when ext_valid_i is high.
- modifiers_o  output  MOD_WIDTH  bits to OR into NEXT for fetch_task_i; combinational.
- pending_o  output  TASKS  bit t is high when pend[t] is nonzero; registered.
- carry_q_o  output  1  latched ALU carry.

## Operation
- **State:** pend[0..TASKS-1], each MOD_WIDTH bits, plus carry_q.
- **Condition vector `new`** is computed each cycle from f2_i:
  - ALTO_F2_BUS_ZERO: bit0 = (bus_i == 0).
  - ALTO_F2_SH_NEG: bit0 = shifter_i[15].
  - ALTO_F2_SH_ZERO: bit0 = (shifter_i == 0).
  - ALTO_F2_BUS: new = bus_i[MOD_WIDTH-1:0].
  - ALTO_F2_ALUCY: bit0 = carry_q, the latched carry, not alu_carry_i.
  - Any other code: 0.
  - Then new |= ext_valid_i ? ext_mod_i : 0.
- **Output when advance_i = 0:** modifiers_o = pend[fetch_task_i]. No state change; all registers hold.
- **advance_i = 1 and fetch_task_i == cur_task_i (bypass):**
  - modifiers_o = new.
  - pend[cur_task_i] <= 0.
- **advance_i = 1 and fetch_task_i != cur_task_i:**
  - modifiers_o = pend[fetch_task_i].
  - pend[fetch_task_i] <= 0.
  - pend[cur_task_i] <= new. This replaces the old value; it is not ORed.
- **Carry latch:** carry_q <= alu_carry_i when advance_i && load_l_i; otherwise it holds.
- **pending_o:** recomputed from the next-state pend values, so it is valid the cycle after each update.
- **MOD_WIDTH = 1:** ALTO_F2_BUS yields bus_i[0].

## Timing
- **Reset:** rst_i clears all pend[], carry_q and pending_o to 0 immediately, without waiting for a clock edge.
  - While reset is held, modifiers_o = 0 unless the bypass path is active (advance_i=1, fetch_task_i == cur_task_i, and new is nonzero).
  - A pend value captured in the cycle reset asserts is lost; reset wins.
- **Latency:**
  - Bypass path: 0 cycles, combinational.
  - Stored path: 1 edge from capture to availability. A fetch of task t in the cycle after t completes sees the value.
- **Ordering within one edge:**
  - The ALUCY condition uses carry_q from before the edge. When a single instruction both loads L and tests ALUCY, it sees the previous carry.
  - If that instruction's ext contribution is also zero, modifiers_o reflects the old carry only.
- **Repeated completion:** if a task completes twice without an intervening fetch of it, the second capture overwrites the first.
- **Idle fetch:** fetching a task with pend = 0 returns 0 and is legal.
- **Out-of-range task number:** when TASKS < 2^TASK_BITS is impossible by construction, no guard is needed.

## Test plan
- **Reset:** assert rst_i mid-cycle with pend[3] = 10'h2A5 and carry_q = 1. Required: pending_o = 0 and carry_q_o = 0 before the next edge; fetch of task 3 returns 0.
- **Bypass:** task 0 completes with f2 = ALTO_F2_BUS, bus = 16'hFFFF, fetch_task = 0. Required: modifiers_o = 10'h3FF in the same cycle; pend[0] = 0 afterwards.
- **Task switch:** task 0 completes with ALTO_F2_SH_NEG, shifter = 16'h8000, while task 5 is fetched. Then task 0 is fetched 3 idle cycles later with advance_i = 1. Required: modifiers_o = 1, and pending_o[0] clears on the next edge.
- **Latched carry:**
  - First, an instruction with load_l_i = 1 and alu_carry_i = 1 completes.
  - Next, an ALUCY instruction with alu_carry_i = 0 and bypass completes. Required: modifiers_o = 1.
  - A following ALUCY instruction returns 0 only if carry was reloaded with 0.
- **Ext OR:** ext_valid_i = 1, ext_mod_i = 10'h0F0, f2 = ALTO_F2_BUS_ZERO, bus = 0, bypass. Required: modifiers_o = 10'h0F1.
- **Parameters:** with TASKS = 4 and MOD_WIDTH = 1, BUS mode with bus = 16'h0003 yields 1. Overwrite without fetch keeps only the last value: 0, then 1 gives 1.
